boss_motion_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 17 +
 rtl/boss_tick_div.sv | 28 ++
 rtl/boss_motion_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_boss_motion_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the shooting game: boss sequencer states and screen/sprite geometry.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENTER  = 2'd1,
      PATROL = 2'd2,
      DEAD   = 2'd3
   } state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int BOSS_W   = 216;
   localparam int BOSS_H   = 110;
   localparam int BOSS_Y0  = 166;

endpackage

// File: rtl/boss_tick_div.sv
// Move-tick enable generator: pulses tick once every TICK_DIV clocks, restartable via clr.
module boss_tick_div #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/boss_motion_ctrl.sv
// Boss sequencer: waits for a clear field, slides the boss in, patrols, enrages and reports defeat.
// Optional vertical bobbing in patrol is enabled by defining BOSS_VDRIFT_EN.
module boss_motion_ctrl
   import game_pkg::*;
#(
   parameter int N_ENEMY  = 4,
   parameter int XW       = 10,
   parameter int HPW      = 10,
   parameter int X_START  = 0,
   parameter int X_ENTRY  = 344,
   parameter int X_LEFT   = 100,
   parameter int X_RIGHT  = 424,
   parameter int Y0       = BOSS_Y0,
   parameter int STEP     = 1,
   parameter int TICK_DIV = 1,
   parameter int HP_RAGE  = 100,
   parameter int Y_AMP    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_ENEMY-1:0] enemy_alive,
   input  logic [HPW-1:0]     boss_hp,
   output logic [XW-1:0]      boss_x,
   output logic [XW-1:0]      boss_y,
   output logic               boss_active,
   output logic               boss_rage,
   output logic               boss_dir,
   output logic               boss_defeated
);

   if (X_RIGHT + BOSS_W > SCREEN_W || Y0 + Y_AMP + BOSS_H > SCREEN_H) begin : g_geom_chk
      $error("boss_motion_ctrl: boss sprite would leave the screen");
   end

   // Positions are held one bit wider so additions never wrap at 2^XW.
   localparam logic [XW:0]    XS  = (XW+1)'(X_START);
   localparam logic [XW:0]    XE  = (XW+1)'(X_ENTRY);
   localparam logic [XW:0]    XL  = (XW+1)'(X_LEFT);
   localparam logic [XW:0]    XR  = (XW+1)'(X_RIGHT);
   localparam logic [XW:0]    YT  = (XW+1)'(Y0);
   localparam logic [XW:0]    ST1 = (XW+1)'(STEP);
   localparam logic [XW:0]    ST2 = (XW+1)'(2 * STEP);
   localparam logic [HPW-1:0] HR  = HPW'(HP_RAGE);

   state_t        state, state_nxt;
   logic [XW-1:0] x_nxt, y_nxt;
   logic          dir_nxt, rage_nxt;
   logic          clear, alive, go, tick;
   logic [XW:0]   step, x_ext, x_up;
   logic [XW-1:0] x_dn;

   assign clear = ~|enemy_alive;
   assign alive = (boss_hp != '0);
   assign go    = (state == IDLE) && clear && alive;
   assign step  = boss_rage ? ST2 : ST1;
   assign x_ext = {1'b0, boss_x};
   assign x_up  = x_ext + step;
   assign x_dn  = boss_x - step[XW-1:0];

   boss_tick_div #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (go),
      .tick  (tick)
   );

   always_comb begin
      state_nxt = state;
      x_nxt     = boss_x;
      dir_nxt   = boss_dir;
      case (state)
         IDLE: begin
            x_nxt   = XS[XW-1:0];
            dir_nxt = 1'b1;
            if (go) state_nxt = ENTER;
         end
         ENTER: begin
            if (!alive) begin
               state_nxt = DEAD;
            end else if (tick) begin
               dir_nxt = 1'b1;
               if (x_up >= XE) begin
                  x_nxt     = XE[XW-1:0];
                  state_nxt = PATROL;
               end else begin
                  x_nxt = x_up[XW-1:0];
               end
            end
         end
         PATROL: begin
            if (!alive) begin
               state_nxt = DEAD;
            end else if (tick) begin
               if (boss_dir) begin
                  if (x_up >= XR) begin
                     x_nxt   = XR[XW-1:0];
                     dir_nxt = 1'b0;
                  end else begin
                     x_nxt = x_up[XW-1:0];
                  end
               end else begin
                  // Compare before subtracting so the left clamp cannot underflow.
                  if (x_ext <= XL + step) begin
                     x_nxt   = XL[XW-1:0];
                     dir_nxt = 1'b1;
                  end else begin
                     x_nxt = x_dn;
                  end
               end
            end
         end
         DEAD: begin
            state_nxt = IDLE;
            x_nxt     = XS[XW-1:0];
         end
         default: begin
            state_nxt = IDLE;
            x_nxt     = XS[XW-1:0];
         end
      endcase

      if (state_nxt == IDLE) rage_nxt = 1'b0;
      else                   rage_nxt = boss_rage | ((state == PATROL) && (boss_hp <= HR));
   end

`ifdef BOSS_VDRIFT_EN
   localparam logic [XW:0] YB = (XW+1)'(Y0 + Y_AMP);

   logic        ydown, ydown_nxt;
   logic [XW:0] y_ext;

   assign y_ext = {1'b0, boss_y};

   always_comb begin
      y_nxt     = boss_y;
      ydown_nxt = ydown;
      if (state_nxt == IDLE || state_nxt == DEAD) begin
         y_nxt     = YT[XW-1:0];
         ydown_nxt = 1'b1;
      end else if (state == PATROL && tick) begin
         if (ydown) begin
            if (y_ext + (XW+1)'(1) >= YB) begin
               y_nxt     = YB[XW-1:0];
               ydown_nxt = 1'b0;
            end else begin
               y_nxt = boss_y + XW'(1);
            end
         end else begin
            if (y_ext <= YT + (XW+1)'(1)) begin
               y_nxt     = YT[XW-1:0];
               ydown_nxt = 1'b1;
            end else begin
               y_nxt = boss_y - XW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ydown <= 1'b1;
      else        ydown <= ydown_nxt;
   end
`else
   assign y_nxt = YT[XW-1:0];
`endif

   // All outputs are registered alongside the state so they change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         boss_x        <= XS[XW-1:0];
         boss_y        <= YT[XW-1:0];
         boss_active   <= 1'b0;
         boss_rage     <= 1'b0;
         boss_dir      <= 1'b1;
         boss_defeated <= 1'b0;
      end else begin
         state         <= state_nxt;
         boss_x        <= x_nxt;
         boss_y        <= y_nxt;
         boss_active   <= (state_nxt == ENTER) || (state_nxt == PATROL);
         boss_rage     <= rage_nxt;
         boss_dir      <= dir_nxt;
         boss_defeated <= (state_nxt == DEAD);
      end
   end

endmodule

// File: tb/tb_boss_motion_ctrl.sv
// Directed bench for boss_motion_ctrl: vector table for the main flight path plus
// hand-written sequences for defeat, tick division, re-entry and asynchronous reset.
module tb_boss_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] ena_a = 4'b1111;
   logic [9:0] hp_a = '0;
   logic [3:0] ena_b = 4'b1111;
   logic [9:0] hp_b = '0;

   logic [9:0] x_a, y_a, x_b, y_b;
   logic       act_a, rage_a, dir_a, def_a;
   logic       act_b, rage_b, dir_b, def_b;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   boss_motion_ctrl dut_a (
      .clk           (clk),
      .rst_n         (rst_n),
      .enemy_alive   (ena_a),
      .boss_hp       (hp_a),
      .boss_x        (x_a),
      .boss_y        (y_a),
      .boss_active   (act_a),
      .boss_rage     (rage_a),
      .boss_dir      (dir_a),
      .boss_defeated (def_a)
   );

   boss_motion_ctrl #(.TICK_DIV(4)) dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .enemy_alive   (ena_b),
      .boss_hp       (hp_b),
      .boss_x        (x_b),
      .boss_y        (y_b),
      .boss_active   (act_b),
      .boss_rage     (rage_b),
      .boss_dir      (dir_b),
      .boss_defeated (def_b)
   );

   typedef struct {
      logic [3:0] ena;
      int         hp;
      int         n;
      int         x;
      int         act;
      int         rage;
      int         dir;
      int         def;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   task automatic add(input logic [3:0] ena, input int hp, input int n, input int x,
                      input int act, input int rage, input int dir, input int def);
      vec_t v;
      v.ena = ena; v.hp = hp; v.n = n; v.x = x;
      v.act = act; v.rage = rage; v.dir = dir; v.def = def;
      vecs.push_back(v);
   endtask

   initial begin
      int pulses;
      int ymin, ymax;

      // Inputs change at negedge; outputs are sampled at the following negedges.
      //   ena      hp   n    x    act rage dir def
      add(4'b0010, 500, 50,  0,   0,  0,   1,  0);  // enemy present: stay idle
      add(4'b0000, 500, 1,   0,   1,  0,   1,  0);  // field clear: enter begins
      add(4'b0000, 500, 1,   1,   1,  0,   1,  0);
      add(4'b1111, 500, 199, 200, 1,  0,   1,  0);  // respawns ignored
      add(4'b1111, 500, 143, 343, 1,  0,   1,  0);
      add(4'b1111, 500, 1,   344, 1,  0,   1,  0);  // entry done -> patrol
      add(4'b1111, 500, 76,  420, 1,  0,   1,  0);
      add(4'b1111, 500, 3,   423, 1,  0,   1,  0);
      add(4'b1111, 500, 1,   424, 1,  0,   0,  0);  // right clamp + turn
      add(4'b1111, 500, 1,   423, 1,  0,   0,  0);
      add(4'b1111, 500, 322, 101, 1,  0,   0,  0);
      add(4'b1111, 500, 1,   100, 1,  0,   1,  0);  // left clamp + turn
      add(4'b1111, 500, 1,   101, 1,  0,   1,  0);
      add(4'b1111, 101, 1,   102, 1,  0,   1,  0);
      add(4'b1111, 100, 1,   103, 1,  1,   1,  0);  // rage set, this move still 1
      add(4'b1111, 100, 1,   105, 1,  1,   1,  0);
      add(4'b1111, 150, 1,   107, 1,  1,   1,  0);  // rage sticks
      add(4'b1111, 150, 10,  127, 1,  1,   1,  0);
      add(4'b1111, 0,   1,   127, 0,  1,   1,  1);  // dead
      add(4'b1111, 0,   1,   0,   0,  0,   1,  0);  // back to idle
      add(4'b0000, 0,   5,   0,   0,  0,   1,  0);  // clear but hp 0: no entry

      // Reset state
      cyc(1);
      chk("rst.x", x_a, 0);
      chk("rst.y", y_a, 166);
      chk("rst.active", act_a, 0);
      chk("rst.rage", rage_a, 0);
      chk("rst.dir", dir_a, 1);
      chk("rst.defeated", def_a, 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         ena_a = vecs[i].ena;
         hp_a  = 10'(vecs[i].hp);
         cyc(vecs[i].n);
         chk($sformatf("v%0d.x", i), x_a, vecs[i].x);
         chk($sformatf("v%0d.active", i), act_a, vecs[i].act);
         chk($sformatf("v%0d.rage", i), rage_a, vecs[i].rage);
         chk($sformatf("v%0d.dir", i), dir_a, vecs[i].dir);
         chk($sformatf("v%0d.defeated", i), def_a, vecs[i].def);
`ifndef BOSS_VDRIFT_EN
         chk($sformatf("v%0d.y", i), y_a, 166);
`endif
      end

      // Defeat during entry at x = 200: single pulse, then idle at X_START
      do_reset();
      ena_a = 4'b0000;
      hp_a  = 10'd500;
      cyc(201);
      chk("die.x_before", x_a, 200);
      hp_a = 10'd0;
      cyc(1);
      chk("die.defeated", def_a, 1);
      chk("die.active", act_a, 0);
      chk("die.x_hold", x_a, 200);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         if (def_a) pulses++;
      end
      chk("die.extra_pulses", pulses, 0);
      chk("die.x_idle", x_a, 0);
      chk("die.active_idle", act_a, 0);

      // TICK_DIV = 4: first move 4 clocks after entry, then every 4th clock
      do_reset();
      ena_b = 4'b0000;
      hp_b  = 10'd500;
      for (int k = 1; k <= 9; k++) begin
         cyc(1);
         chk($sformatf("div.x%0d", k), x_b, (k - 1) / 4);
      end
      hp_b = 10'd0;
      cyc(2);
      chk("div.dead_x", x_b, 0);
      cyc(1);
      hp_b = 10'd500;
      for (int k = 1; k <= 5; k++) begin
         cyc(1);
         chk($sformatf("div.rx%0d", k), x_b, (k - 1) / 4);
      end
      hp_b = 10'd0;

      // Asynchronous reset mid-patrol
      do_reset();
      ena_a = 4'b0000;
      hp_a  = 10'd500;
      cyc(345);
      chk("ar.x_patrol", x_a, 344);
      ymin = 1000;
      ymax = 0;
      for (int k = 0; k < 40; k++) begin
         if (y_a < ymin) ymin = y_a;
         if (y_a > ymax) ymax = y_a;
         cyc(1);
      end
      chk("ar.x_before", x_a, 384);
      chk("ar.active_before", act_a, 1);
`ifdef BOSS_VDRIFT_EN
      chk("vdrift.ymin", ymin, 166);
      chk("vdrift.ymax", ymax, 182);
`else
      chk("ar.ymin", ymin, 166);
      chk("ar.ymax", ymax, 166);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.x", x_a, 0);
      chk("ar.y", y_a, 166);
      chk("ar.active", act_a, 0);
      chk("ar.dir", dir_a, 1);
      chk("ar.rage", rage_a, 0);
      chk("ar.defeated", def_a, 0);
      cyc(1);
      chk("ar.defeated_held", def_a, 0);
      chk("ar.x_held", x_a, 0);
      rst_n = 1'b1;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
